// File: rtl/bitsel_pkg.sv
// rtl/bitsel_pkg.sv - shared op and state enums for the bit-select write engine
package bitsel_pkg;

  typedef enum logic [1:0] {
    WRITE  = 2'd0,
    SET    = 2'd1,
    CLR    = 2'd2,
    TOGGLE = 2'd3
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/bitsel_slice_merge.sv
// rtl/bitsel_slice_merge.sv - lane-masked combinational merge of one slice
module bitsel_slice_merge
  import bitsel_pkg::*;
#(
  parameter int SLICE_W = 16,
  parameter int LANE_W  = 4,
  localparam int NLANE  = SLICE_W / LANE_W
) (
  input  logic [SLICE_W-1:0] old_slice,
  input  logic [SLICE_W-1:0] data,
  input  logic [NLANE-1:0]   lane_en,
  input  op_e                op,
  output logic [SLICE_W-1:0] new_slice
);

  // Apply the op per enabled lane; disabled lanes pass the old bits through
  always_comb begin
    new_slice = old_slice;
    for (int i = 0; i < NLANE; i++) begin
      if (lane_en[i]) begin
        case (op)
          WRITE:   new_slice[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
          SET:     new_slice[i*LANE_W +: LANE_W] = old_slice[i*LANE_W +: LANE_W] | data[i*LANE_W +: LANE_W];
          CLR:     new_slice[i*LANE_W +: LANE_W] = old_slice[i*LANE_W +: LANE_W] & ~data[i*LANE_W +: LANE_W];
          default: new_slice[i*LANE_W +: LANE_W] = old_slice[i*LANE_W +: LANE_W] ^ data[i*LANE_W +: LANE_W];
        endcase
      end
    end
  end

endmodule

// File: rtl/bitsel_write_engine.sv
// rtl/bitsel_write_engine.sv - sliced read-modify-write engine over a wide state vector
module bitsel_write_engine
  import bitsel_pkg::*;
#(
  parameter int TOTAL_W = 1024,
  parameter int SLICE_W = 16,
  parameter int LANE_W  = 4,
  parameter int WRAP    = 1,
  localparam int OFS_W  = $clog2(TOTAL_W),
  localparam int NLANE  = SLICE_W / LANE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OFS_W-1:0]   in_ofs,
  input  logic [SLICE_W-1:0] in_data,
  input  logic [NLANE-1:0]   in_lane_en,
  input  logic [1:0]         in_op,
  input  logic               clear_req,
  input  logic [OFS_W-1:0]   rd_ofs,
  output logic [SLICE_W-1:0] rd_data,
  output logic [TOTAL_W-1:0] dout,
  output logic               busy,
  output logic               err_oob
);

  localparam int NCHUNK = TOTAL_W / SLICE_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s1_valid_q, s1_valid_d;
  logic [OFS_W-1:0]   s1_ofs_q, s1_ofs_d;
  logic [SLICE_W-1:0] s1_data_q, s1_data_d;
  logic [NLANE-1:0]   s1_lane_q, s1_lane_d;
  op_e                s1_op_q, s1_op_d;
  logic [TOTAL_W-1:0] dout_q, dout_d;
  logic [SLICE_W-1:0] rd_data_q, rd_data_d;
  logic               err_oob_q, err_oob_d;
  logic [SLICE_W-1:0] old_slice, new_slice;
  logic               accept;

  assign in_ready = (state_q == IDLE) && !clear_req && rst_n;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == SWEEP);
  assign dout     = dout_q;
  assign rd_data  = rd_data_q;
  assign err_oob  = err_oob_q;

  // Gather the current contents of the pending slice (wrapped index; dropped bits are masked at commit)
  always_comb begin
    logic [OFS_W:0] idx;
    idx       = '0;
    old_slice = '0;
    for (int j = 0; j < SLICE_W; j++) begin
      idx          = {1'b0, s1_ofs_q} + (OFS_W+1)'(j);
      old_slice[j] = dout_q[idx[OFS_W-1:0]];
    end
  end

  bitsel_slice_merge #(
    .SLICE_W (SLICE_W),
    .LANE_W  (LANE_W)
  ) u_merge (
    .old_slice (old_slice),
    .data      (s1_data_q),
    .lane_en   (s1_lane_q),
    .op        (s1_op_q),
    .new_slice (new_slice)
  );

  // Next state: S1 load, commit scatter, sweep clear (applied last so it wins), read-back of post-commit state
  always_comb begin
    logic [OFS_W:0] idx;
    idx        = '0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    s1_valid_d = accept;
    s1_ofs_d   = accept ? in_ofs : s1_ofs_q;
    s1_data_d  = accept ? in_data : s1_data_q;
    s1_lane_d  = accept ? in_lane_en : s1_lane_q;
    s1_op_d    = accept ? op_e'(in_op) : s1_op_q;
    dout_d     = dout_q;
    err_oob_d  = 1'b0;
    rd_data_d  = '0;

    if (s1_valid_q) begin
      for (int j = 0; j < SLICE_W; j++) begin
        idx = {1'b0, s1_ofs_q} + (OFS_W+1)'(j);
        if (WRAP != 0 || !idx[OFS_W]) begin
          dout_d[idx[OFS_W-1:0]] = new_slice[j];
        end else if (s1_lane_q[j/LANE_W]) begin
          err_oob_d = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        dout_d[cnt_q*SLICE_W +: SLICE_W] = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NCHUNK-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase

    for (int j = 0; j < SLICE_W; j++) begin
      idx = {1'b0, rd_ofs} + (OFS_W+1)'(j);
      if (WRAP != 0 || !idx[OFS_W]) begin
        rd_data_d[j] = dout_d[idx[OFS_W-1:0]];
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_ofs_q   <= '0;
      s1_data_q  <= '0;
      s1_lane_q  <= '0;
      s1_op_q    <= WRITE;
      dout_q     <= '0;
      rd_data_q  <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_ofs_q   <= s1_ofs_d;
      s1_data_q  <= s1_data_d;
      s1_lane_q  <= s1_lane_d;
      s1_op_q    <= s1_op_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
      err_oob_q  <= err_oob_d;
    end
  end

endmodule
